// File: rtl/synth_voice_pkg.sv
// Shared definitions for the polyphonic voice allocator and its ADSR voices.
package synth_voice_pkg;

    // Per-voice lifecycle as seen by the allocator.
    typedef enum logic [1:0] {
        V_IDLE      = 2'd0,
        V_HELD      = 2'd1,
        V_RELEASING = 2'd2,
        V_RETRIG    = 2'd3
    } voice_state_e;

    // MIDI note number width.
    localparam int NOTE_W = 7;

    // Gate-low time on steal/retrigger; also used by the ADSR bench.
    localparam int RETRIG_CYCLES_DFLT = 2;

    // One-hot class mask selecting a single voice state.
    function automatic logic [3:0] state_mask(input voice_state_e st);
        state_mask = 4'b0001 << st;
    endfunction

endpackage

// File: rtl/voice_age_picker.sv
// Combinational search for the oldest voice within a chosen state class.
// Ties resolve to the lowest voice index.
module voice_age_picker #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4,
    parameter int IDX_W      = 2
) (
    input  logic [2*NUM_VOICES-1:0]     i_state_flat,
    input  logic [NUM_VOICES*AGE_W-1:0] i_age_flat,
    input  logic [3:0]                  i_class_mask,
    output logic [IDX_W-1:0]            o_idx,
    output logic                        o_found
);
    import synth_voice_pkg::*;

    voice_state_e     w_st;
    logic [AGE_W-1:0] w_age;
    logic [AGE_W-1:0] w_best;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Scan upward; strict greater-than keeps the lowest index on equal ages.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_best  = '0;
        w_st    = V_IDLE;
        w_age   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_st  = voice_state_e'(i_state_flat[2*i +: 2]);
            w_age = i_age_flat[i*AGE_W +: AGE_W];
            if (i_class_mask[w_st] && (!w_found || (w_age > w_best))) begin
                w_found = 1'b1;
                w_best  = w_age;
                w_idx   = IDX_W'(i);
            end
        end
    end

    assign o_idx   = w_idx;
    assign o_found = w_found;

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: assigns note events to a bank of ADSR voices,
// steals the oldest voice when all are busy, and drives per-voice gates.
module voice_allocator #(
    parameter int NUM_VOICES    = 4,
    parameter int NOTE_W        = synth_voice_pkg::NOTE_W,
    parameter int AGE_W         = 4,
    parameter int RETRIG_CYCLES = synth_voice_pkg::RETRIG_CYCLES_DFLT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]        voice_done,
    output logic [NUM_VOICES-1:0]        gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         steal_pulse,
    output logic [3:0]                   active_count
);
    import synth_voice_pkg::*;

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RETRIG_CYCLES - 1);
    localparam logic [3:0] MASK_REL  = 4'b0100;
    localparam logic [3:0] MASK_HELD = 4'b0010;

    // Registered per-voice state
    voice_state_e          r_state [NUM_VOICES];
    logic [NOTE_W-1:0]     r_note  [NUM_VOICES];
    logic [AGE_W-1:0]      r_age   [NUM_VOICES];
    logic [CNT_W-1:0]      r_cnt   [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate;
    logic                  r_steal;
    logic [3:0]            r_active;

    // Next-state values
    voice_state_e          w_state_nx [NUM_VOICES];
    logic [NOTE_W-1:0]     w_note_nx  [NUM_VOICES];
    logic [AGE_W-1:0]      w_age_nx   [NUM_VOICES];
    logic [CNT_W-1:0]      w_cnt_nx   [NUM_VOICES];
    logic [3:0]            w_active_nx;

    logic [2*NUM_VOICES-1:0]     w_state_flat;
    logic [NUM_VOICES*AGE_W-1:0] w_age_flat;

    logic             w_ready;
    logic             w_on_acc;
    logic             w_off_acc;
    logic             w_match_found;
    logic [IDX_W-1:0] w_match_idx;
    logic             w_idle_found;
    logic [IDX_W-1:0] w_idle_idx;
    logic             w_rel_found;
    logic [IDX_W-1:0] w_rel_idx;
    logic             w_held_found;
    logic [IDX_W-1:0] w_held_idx;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_retrig;
    logic             w_pick_steal;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
        assign w_state_flat[2*g +: 2]        = r_state[g];
        assign w_age_flat[g*AGE_W +: AGE_W]  = r_age[g];
        assign voice_note[g*NOTE_W +: NOTE_W] = r_note[g];
    end

    // Oldest releasing voice: reused before any held note is cut off.
    voice_age_picker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_pick_rel (
        .i_state_flat (w_state_flat),
        .i_age_flat   (w_age_flat),
        .i_class_mask (MASK_REL),
        .o_idx        (w_rel_idx),
        .o_found      (w_rel_found)
    );

    // Oldest held voice: the steal victim of last resort.
    voice_age_picker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_pick_held (
        .i_state_flat (w_state_flat),
        .i_age_flat   (w_age_flat),
        .i_class_mask (MASK_HELD),
        .o_idx        (w_held_idx),
        .o_found      (w_held_found)
    );

    // Events stall while any voice is counting out its retrigger gap.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_state[i] == V_RETRIG) w_ready = 1'b0;
        end
    end

    assign w_on_acc  = ev_valid && w_ready && ev_on;
    assign w_off_acc = ev_valid && w_ready && !ev_on;

    // Lowest-index held voice already playing this note, and lowest free voice.
    always_comb begin
        w_match_found = 1'b0;
        w_match_idx   = '0;
        w_idle_found  = 1'b0;
        w_idle_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_state[i] == V_HELD && r_note[i] == ev_note) begin
                w_match_found = 1'b1;
                w_match_idx   = IDX_W'(i);
            end
            if (r_state[i] == V_IDLE) begin
                w_idle_found = 1'b1;
                w_idle_idx   = IDX_W'(i);
            end
        end
    end

    // Note-on target priority: same note, free voice, oldest releasing, oldest held.
    always_comb begin
        w_pick_idx    = w_held_idx;
        w_pick_retrig = 1'b1;
        w_pick_steal  = w_held_found;
        if (w_match_found) begin
            w_pick_idx   = w_match_idx;
            w_pick_steal = 1'b0;
        end else if (w_idle_found) begin
            w_pick_idx    = w_idle_idx;
            w_pick_retrig = 1'b0;
            w_pick_steal  = 1'b0;
        end else if (w_rel_found) begin
            w_pick_idx   = w_rel_idx;
            w_pick_steal = 1'b0;
        end
    end

    // Per-voice next state: an event on a voice overrides its own progression.
    always_comb begin
        logic w_sel;
        w_sel       = 1'b0;
        w_active_nx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_state_nx[i] = r_state[i];
            w_note_nx[i]  = r_note[i];
            w_age_nx[i]   = r_age[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_sel         = w_on_acc && (w_pick_idx == IDX_W'(i));

            if (w_on_acc) begin
                if (w_sel) begin
                    w_age_nx[i] = '0;
                end else if (r_state[i] != V_IDLE && r_age[i] != AGE_MAX) begin
                    w_age_nx[i] = r_age[i] + 1'b1;
                end
            end

            if (w_sel) begin
                w_note_nx[i] = ev_note;
                if (w_pick_retrig) begin
                    w_state_nx[i] = V_RETRIG;
                    w_cnt_nx[i]   = CNT_LOAD;
                end else begin
                    w_state_nx[i] = V_HELD;
                end
            end else if (w_off_acc && (r_state[i] == V_HELD || r_state[i] == V_RETRIG)
                         && r_note[i] == ev_note) begin
                w_state_nx[i] = V_RELEASING;
            end else begin
                case (r_state[i])
                    V_RETRIG: begin
                        if (r_cnt[i] == '0) w_state_nx[i] = V_HELD;
                        else                w_cnt_nx[i]   = r_cnt[i] - 1'b1;
                    end
                    V_RELEASING: begin
                        if (voice_done[i]) w_state_nx[i] = V_IDLE;
                    end
                    default: ;
                endcase
            end

            if (w_state_nx[i] != V_IDLE) w_active_nx = w_active_nx + 4'd1;
        end
    end

    // State, gate and status registers; reset drops gates and any pending retrigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_state[i] <= V_IDLE;
                r_note[i]  <= '0;
                r_age[i]   <= '0;
                r_cnt[i]   <= '0;
            end
            r_gate   <= '0;
            r_steal  <= 1'b0;
            r_active <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_state[i] <= w_state_nx[i];
                r_note[i]  <= w_note_nx[i];
                r_age[i]   <= w_age_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_gate[i]  <= (w_state_nx[i] == V_HELD);
            end
            r_steal  <= w_on_acc && w_pick_steal;
            r_active <= w_active_nx;
        end
    end

    assign ev_ready     = w_ready;
    assign gate         = r_gate;
    assign steal_pulse  = r_steal;
    assign active_count = r_active;

endmodule
